// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill arbiter: FSM state encoding and
// block geometry / memory timing constants.
package cache_pkg;

    // Arbiter states; 2-bit encoding shared by the RTL and anything that
    // decodes the state for debug.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_D = 2'd2,
        FILL_I = 2'd3
    } state_t;

    // Default block geometry: 8 words of 16 bits = 16-byte blocks.
    localparam int WORDS_PER_BLK_DEF = 8;
    localparam int BLK_OFF_W_DEF     = $clog2(2 * WORDS_PER_BLK_DEF);

    // Main memory returns read data this many cycles after the read issue.
    localparam int MEM_LATENCY = 4;

endpackage

// File: rtl/fill_word_counter.sv
// Word-index counter used to track read issues and data returns within
// one block fill. Clear has priority over increment.
module fill_word_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // Count register: synchronous reset, clear, then increment.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = &r_count;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single main memory between I-cache fills, D-cache fills
// and D-cache write-through stores. Fixed priority store > D fill > I fill,
// decided only in IDLE. Fills issue 8 back-to-back reads and forward the
// returned words to the owning cache as they arrive.
module cache_fill_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = WORDS_PER_BLK_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_miss,
    input  logic [ADDR_W-1:0]                i_miss_addr,
    input  logic                             d_miss,
    input  logic [ADDR_W-1:0]                d_miss_addr,
    input  logic                             d_wr_req,
    input  logic [ADDR_W-1:0]                d_wr_addr,
    input  logic [DATA_W-1:0]                d_wr_data,
    output logic                             mem_en,
    output logic                             mem_wr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    input  logic                             mem_valid,
    output logic [DATA_W-1:0]                fill_data,
    output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
    output logic                             fill_i_we,
    output logic                             fill_d_we,
    output logic                             fill_i_done,
    output logic                             fill_d_done,
    output logic                             d_wr_ack,
    output logic                             busy
);

    localparam int CNT_W     = $clog2(WORDS_PER_BLK);
    localparam int BLK_OFF_W = $clog2(2 * WORDS_PER_BLK);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_issue_done;

    logic                w_capture;
    logic                w_capture_wr;
    logic [ADDR_W-1:0]   w_sel_addr;

    logic                w_filling;
    logic                w_issue;
    logic                w_rx;
    logic                w_rx_last;
    logic [CNT_W-1:0]    w_issue_cnt;
    logic                w_issue_cnt_last;
    logic [CNT_W-1:0]    w_rx_cnt;
    logic                w_rx_cnt_last;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   w_issue_off;

    // Fill datapath decode. Issue stops once all words have gone out; the
    // receive side runs independently off mem_valid.
    assign w_filling   = (r_state == FILL_D) || (r_state == FILL_I);
    assign w_issue     = w_filling && !r_issue_done;
    assign w_rx        = w_filling && mem_valid;
    assign w_rx_last   = w_rx && w_rx_cnt_last;
    assign w_base      = {r_addr[ADDR_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
    assign w_issue_off = {{(ADDR_W-CNT_W-1){1'b0}}, w_issue_cnt, 1'b0};

    fill_word_counter #(.W(CNT_W)) u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_rx_last),
        .i_inc   (w_issue),
        .o_count (w_issue_cnt),
        .o_last  (w_issue_cnt_last)
    );

    fill_word_counter #(.W(CNT_W)) u_rx_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_rx_last),
        .i_inc   (w_rx),
        .o_count (w_rx_cnt),
        .o_last  (w_rx_cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant selection; arbitration only in IDLE.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_capture_wr = 1'b0;
        w_sel_addr   = r_addr;
        case (r_state)
            IDLE: begin
                if (d_wr_req) begin
                    w_next_state = WRITE;
                    w_capture    = 1'b1;
                    w_capture_wr = 1'b1;
                    w_sel_addr   = d_wr_addr;
                end else if (d_miss) begin
                    w_next_state = FILL_D;
                    w_capture    = 1'b1;
                    w_sel_addr   = d_miss_addr;
                end else if (i_miss) begin
                    w_next_state = FILL_I;
                    w_capture    = 1'b1;
                    w_sel_addr   = i_miss_addr;
                end
            end
            WRITE: begin
                w_next_state = IDLE;
            end
            FILL_D, FILL_I: begin
                if (w_rx_last) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Address/data capture at grant; store data only for writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_addr <= w_sel_addr;
            if (w_capture_wr) begin
                r_wdata <= d_wr_data;
            end
        end
    end

    // Marks that the last read of the block has been issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_done <= 1'b0;
        end else if (w_rx_last) begin
            r_issue_done <= 1'b0;
        end else if (w_issue && w_issue_cnt_last) begin
            r_issue_done <= 1'b1;
        end
    end

    // Memory-side outputs, decoded from registered state only.
    assign mem_en    = (r_state == WRITE) || w_issue;
    assign mem_wr    = (r_state == WRITE);
    assign mem_addr  = (r_state == WRITE) ? r_addr :
                       w_issue            ? (w_base + w_issue_off) : '0;
    assign mem_wdata = (r_state == WRITE) ? r_wdata : '0;
    assign d_wr_ack  = (r_state == WRITE);
    assign busy      = (r_state != IDLE);

    // Cache-side fill outputs follow mem_valid combinationally.
    assign fill_data   = mem_rdata;
    assign fill_word   = w_rx_cnt;
    assign fill_i_we   = (r_state == FILL_I) && mem_valid;
    assign fill_d_we   = (r_state == FILL_D) && mem_valid;
    assign fill_i_done = fill_i_we && w_rx_cnt_last;
    assign fill_d_done = fill_d_we && w_rx_cnt_last;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: a transaction-level model pushes
// the expected memory accesses and fill writes for each batch of requests;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_cache_fill_arbiter;
    import cache_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NW = 8;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          off;
    } mem_t;

    typedef struct {
        bit          is_i;
        int          word;
        logic [15:0] data;
        bit          done;
        int          off;
    } fill_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_miss, d_miss, d_wr_req;
    logic [AW-1:0] i_miss_addr, d_miss_addr, d_wr_addr;
    logic [DW-1:0] d_wr_data;
    logic          mem_en, mem_wr, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, fill_data;
    logic [2:0]    fill_word;
    logic          fill_i_we, fill_d_we, fill_i_done, fill_d_done, d_wr_ack, busy;
    logic          spur;
    logic [15:0]   salt;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int op_start = 0;
    bit chk_idle = 1'b0;

    mem_t  mq[$];
    fill_t fq[$];
    mem_t  me;
    fill_t fe;

    always #5 clk = ~clk;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .fill_i_we(fill_i_we), .fill_d_we(fill_d_we),
        .fill_i_done(fill_i_done), .fill_d_done(fill_d_done),
        .d_wr_ack(d_wr_ack), .busy(busy)
    );

    // Pipelined memory model: read data appears MEM_LATENCY cycles after issue.
    logic        pv[MEM_LATENCY];
    logic [15:0] pa[MEM_LATENCY];

    function automatic logic [15:0] mem_word(logic [15:0] a);
        return (a * 16'd3) ^ salt;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
            end
        end else begin
            pv[0] <= mem_en && !mem_wr;
            pa[0] <= mem_addr;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign mem_valid = pv[MEM_LATENCY-1] | spur;
    assign mem_rdata = pv[MEM_LATENCY-1] ? mem_word(pa[MEM_LATENCY-1]) : 16'hDEAD;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one granted operation becomes a list of memory
    // accesses and cache writes with their cycle offsets from the first access.
    task automatic model_write(input logic [15:0] a, input logic [15:0] d);
        mq.push_back('{wr: 1'b1, addr: a, data: d, off: 0});
    endtask

    task automatic model_fill(input bit is_i, input logic [15:0] a);
        logic [15:0] base;
        logic [15:0] wa;
        base = a & 16'hFFF0;
        for (int k = 0; k < NW; k++) begin
            wa = base + 16'(2 * k);
            mq.push_back('{wr: 1'b0, addr: wa, data: 16'h0, off: k});
            fq.push_back('{is_i: is_i, word: k, data: mem_word(wa),
                           done: (k == NW - 1), off: k + MEM_LATENCY});
        end
    endtask

    // Monitor: compare every memory access and every fill write on the
    // falling edge, in arrival order.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_idle) begin
                check("busy_after_op", {31'b0, busy}, 32'd0);
                chk_idle = 1'b0;
            end
            if (mem_en) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_en", {16'b0, mem_addr}, 32'hFFFFFFFF);
                end else begin
                    me = mq.pop_front();
                    if (me.off == 0) op_start = cyc;
                    check("mem_wr", {31'b0, mem_wr}, {31'b0, me.wr});
                    check("mem_addr", {16'b0, mem_addr}, {16'b0, me.addr});
                    check("d_wr_ack", {31'b0, d_wr_ack}, {31'b0, me.wr});
                    check("mem_timing", cyc - op_start, me.off);
                    if (me.wr) begin
                        check("mem_wdata", {16'b0, mem_wdata}, {16'b0, me.data});
                        chk_idle = 1'b1;
                    end
                end
            end else if (d_wr_ack) begin
                check("stray_ack", 32'd1, 32'd0);
            end
            if (fill_i_we || fill_d_we) begin
                if (fq.size() == 0) begin
                    check("unexpected_fill_we", {30'b0, fill_i_we, fill_d_we}, 32'd0);
                end else begin
                    fe = fq.pop_front();
                    check("fill_i_we", {31'b0, fill_i_we}, {31'b0, fe.is_i});
                    check("fill_d_we", {31'b0, fill_d_we}, {31'b0, !fe.is_i});
                    check("fill_word", {29'b0, fill_word}, fe.word);
                    check("fill_data", {16'b0, fill_data}, {16'b0, fe.data});
                    check("fill_i_done", {31'b0, fill_i_done}, {31'b0, fe.done && fe.is_i});
                    check("fill_d_done", {31'b0, fill_d_done}, {31'b0, fe.done && !fe.is_i});
                    check("fill_timing", cyc - op_start, fe.off);
                    if (fe.done) chk_idle = 1'b1;
                end
            end else if (fill_i_done || fill_d_done) begin
                check("stray_done", 32'd1, 32'd0);
            end
        end
    end

    // Raise a batch of requests together, model them in priority order and
    // hold each until its ack/done, with a bounded wait.
    task automatic run_op(input bit w, input bit d, input bit i,
                          input logic [15:0] wa, input logic [15:0] wd,
                          input logic [15:0] da, input logic [15:0] ia);
        bit finished;
        if (w) model_write(wa, wd);
        if (d) model_fill(1'b0, da);
        if (i) model_fill(1'b1, ia);
        @(negedge clk);
        d_wr_req = w; d_wr_addr = wa; d_wr_data = wd;
        d_miss = d;   d_miss_addr = da;
        i_miss = i;   i_miss_addr = ia;
        finished = 1'b0;
        for (int c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            #1;
            if (d_wr_ack)    d_wr_req = 1'b0;
            if (fill_d_done) d_miss = 1'b0;
            if (fill_i_done) i_miss = 1'b0;
            if (!d_wr_req && !d_miss && !i_miss && !busy &&
                mq.size() == 0 && fq.size() == 0) finished = 1'b1;
        end
        if (!finished) begin
            check("op_timeout", {30'b0, mq.size() != 0, fq.size() != 0}, 32'd0);
            d_wr_req = 1'b0; d_miss = 1'b0; i_miss = 1'b0;
            mq.delete(); fq.delete();
        end
    endtask

    task automatic spurious_valid();
        @(negedge clk);
        #1 spur = 1'b1;
        #1 check("spur_no_we", {30'b0, fill_i_we, fill_d_we}, 32'd0);
        @(negedge clk);
        #1 spur = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"},    {31'b0, mem_en}, 32'd0);
        check({tag, "_mem_wr"},    {31'b0, mem_wr}, 32'd0);
        check({tag, "_mem_addr"},  {16'b0, mem_addr}, 32'd0);
        check({tag, "_mem_wdata"}, {16'b0, mem_wdata}, 32'd0);
        check({tag, "_we_done"},   {27'b0, fill_i_we, fill_d_we, fill_i_done, fill_d_done, d_wr_ack}, 32'd0);
        check({tag, "_busy"},      {31'b0, busy}, 32'd0);
        check({tag, "_fill_word"}, {29'b0, fill_word}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; spur = 1'b0; salt = 16'($urandom);
        i_miss = 0; d_miss = 0; d_wr_req = 0;
        i_miss_addr = 0; d_miss_addr = 0; d_wr_addr = 0; d_wr_data = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Directed: I fill from a mid-block address.
        run_op(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h1236);
        // Directed: all three requests at once -> write, D fill, I fill.
        run_op(1, 1, 1, 16'h2002, 16'h1234, 16'h3458, 16'h5670);
        // Directed: single store.
        run_op(1, 0, 0, 16'h0040, 16'hBEEF, 16'h0, 16'h0);
        // Directed: D fill in the top block of the address space.
        run_op(0, 1, 0, 16'h0, 16'h0, 16'hFFFE, 16'h0);

        // Directed: reset during the 5th issue cycle of an I fill.
        model_fill(1'b1, 16'h4444);
        @(negedge clk);
        i_miss = 1'b1; i_miss_addr = 16'h4444;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; i_miss = 1'b0;
        @(posedge clk);
        #1 mq.delete(); fq.delete(); chk_idle = 1'b0;
        check_reset_outputs("midfill_reset");
        @(negedge clk) rst = 1'b0;
        run_op(0, 0, 1, 16'h0, 16'h0, 16'h0, 16'h7A10);

        // Directed: spurious mem_valid while idle, then a normal fill.
        spurious_valid();
        run_op(0, 1, 0, 16'h0, 16'h0, 16'h9ABC, 16'h0);

        // Random batches of requests with occasional idle spurious valids.
        for (int n = 0; n < 25; n++) begin
            int mask;
            mask = $urandom_range(1, 7);
            if ($urandom_range(0, 3) == 0) spurious_valid();
            run_op(mask[2], mask[1], mask[0], 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
